hack_computer: RTL and testbench
================================

# hack_computer

Top-level 16-bit Hack-architecture computer: a single-cycle CPU fetches from a 32K-word instruction ROM and accesses a memory-mapped data space of 16K RAM words, an 8K-word screen buffer and a keyboard word. It is the system root. Its only external inputs are clock and reset, and the program is preloaded into the ROM array.

## Interface
- No parameters. Fixed widths: 16-bit data, 15-bit ROM address, 15-bit data address.
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- No other ports. Benches access internal state by hierarchical name:
  - ROM array `rom.m[0:32767]`, 16-bit words.
  - RAM `ram.ram16k.m[0:16383]`.
  - Screen `ram.screen.m[0:8191]`.
  - Signals `pc`, `I`, `addressM`, `outM`.
  - CPU internals `cpu.outDR` (D register), `cpu.outAM`, `cpu.outALU`, `cpu.zx/nx/zy/ny/f/no`, `cpu.zr/ng`, `cpu.isWriteDR`.

## Operation
- The CPU executes instruction `I = rom.m[pc[14:0]]`, read combinationally.
- **A-instruction** (I[15]=0):
  - A ← I.
  - PC ← PC+1.
- **C-instruction** (I[15]=1), format `111a cccc ccdd djjj`:
  - ALU y operand = M (inM) if a=1, else A. x operand = D.
  - c bits map in order to zx, nx, zy, ny, f, no.
- **ALU**, applied in sequence:
  - zx: x=0.
  - nx: x=~x.
  - zy: y=0.
  - ny: y=~y.
  - f: out = x+y (16-bit, wraps) if f=1, else x&y.
  - no: out=~out.
  - zr = (out==0).
  - ng = out[15].
- **Destinations**:
  - d1 → A.
  - d2 → D.
  - d3 → writeM (M[A] ← out).
  - M is written at the address A held before this edge.
- **Jump**: take the jump if any of the following holds:
  - j1 and ng.
  - j2 and zr.
  - j3 and neither zr nor ng.
  - If taken, PC ← A (pre-edge value); otherwise PC ← PC+1.
- **PC** is 16 bits and wraps 0xFFFF → 0. The ROM uses the low 15 bits.
- **Memory map** on addressM = A[14:0]:
  - 0x0000–0x3FFF: RAM.
  - 0x4000–0x5FFF: screen.
  - 0x6000: keyboard. Reads 0 because there is no input port; writes are ignored.
  - 0x6001–0x7FFF: reads 0, writes ignored.
- Data reads (inM) are combinational. Writes are synchronous when writeM=1.
- `outM` is the ALU output. It is meaningful only when writeM=1.

## Timing
- Single-cycle: each rising edge commits one instruction's updates to A, D, PC and memory together.
- **Reset** (reset=0), asynchronous:
  - PC, A and D go to 0 immediately.
  - The CPU holds them at 0 and writeM is forced to 0 while reset is asserted.
  - RAM and screen contents are not cleared.
- Execution resumes at ROM[0] on the first rising edge after reset is deasserted.
- Reset asserted mid-program aborts the current instruction; no memory write occurs for it.
- ROM contents are never altered by the hardware.
- Simultaneous A and M destinations (e.g. AM=...): the write goes to the old A address, and A takes the new value.

## Structure
- Shared package holds:
  - Memory-map constants: RAM_TOP=0x3FFF, SCREEN_BASE=0x4000, KBD=0x6000.
  - Instruction field positions.
  - ALU control bit indices.
- Sub-modules:
  - `cpu`, which contains `alu` and `pc`.
  - `rom32k`.
  - `memory`, containing `ram16k` and `screen`.
- `alu` is the natural leaf sub-module, verified standalone.

## Test plan
- **Reset**: run arbitrary code, then assert reset low.
  - pc=0, A=0, D=0 immediately.
  - After release, the first fetch is ROM[0].
- **Load/store**: ROM = 0x0005, 0xEC10, 0x0002, 0xE308.
  - After 4 cycles: D=5, A=2, ram[2]=5.
- **ALU**:
  - @7; D=A; D=D+1 (0xE7D0) → D=8.
  - D=-1 (0xEE90) → D=0xFFFF; ng=1, zr=0.
  - D=0 (0xEA90) → zr=1.
- **Jumps**:
  - D=3; @10; D;JGT (0xE301) → pc=10.
  - D=0; D;JGT → pc increments.
  - 0;JMP (0xEA87) always jumps to A.
- **Screen/unmapped**:
  - @0x4002; M=-1 → screen[2]=0xFFFF.
  - @0x6000; M=1 → no change anywhere; D=M reads 0.
- **Multiply program**: ram[0]=3, ram[1]=4 preloaded; standard loop program R2=R0*R1.
  - Within 1800 ns at a 10 ns clock, ram[2]=12 and the program halts in its final infinite loop.

Source files
------------

// File: rtl/hack_computer_pkg.sv
// Shared definitions for the Hack computer: memory map, instruction fields
// and the address-region decoder used by the data memory.
package hack_computer_pkg;

   localparam logic [14:0] RAM_TOP     = 15'h3FFF;
   localparam logic [14:0] SCREEN_BASE = 15'h4000;
   localparam logic [14:0] SCREEN_TOP  = 15'h5FFF;
   localparam logic [14:0] KBD         = 15'h6000;

   // C-instruction layout: 111a cccc ccdd djjj
   localparam int I_TYPE = 15;
   localparam int I_A    = 12;
   localparam int I_ZX   = 11;
   localparam int I_NX   = 10;
   localparam int I_ZY   = 9;
   localparam int I_NY   = 8;
   localparam int I_F    = 7;
   localparam int I_NO   = 6;
   localparam int D_A    = 5;
   localparam int D_D    = 4;
   localparam int D_M    = 3;
   localparam int J_LT   = 2;
   localparam int J_EQ   = 1;
   localparam int J_GT   = 0;

   typedef enum logic [1:0] {
      REGION_RAM,
      REGION_SCREEN,
      REGION_KBD,
      REGION_NONE
   } region_t;

   function automatic region_t decode_region(input logic [14:0] addr);
      if (addr <= RAM_TOP) begin
         return REGION_RAM;
      end else if (addr >= SCREEN_BASE && addr <= SCREEN_TOP) begin
         return REGION_SCREEN;
      end else if (addr == KBD) begin
         return REGION_KBD;
      end else begin
         return REGION_NONE;
      end
   endfunction

endpackage

// File: rtl/hack_computer_if.sv
// CPU-to-data-memory bus: address, write data/strobe from the CPU and
// combinational read data back from memory.
interface hack_computer_if;
   logic [15:0] inM;
   logic [15:0] outM;
   logic [14:0] addressM;
   logic        writeM;

   modport master (
      input  inM,
      output outM,
      output addressM,
      output writeM
   );

   modport slave (
      output inM,
      input  outM,
      input  addressM,
      input  writeM
   );
endinterface

// File: rtl/hack_computer_alu.sv
// Hack ALU: purely combinational, controls applied in the order
// zx, nx, zy, ny, f, no.
module alu (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] xs;
   logic [15:0] ys;
   logic [15:0] res;

   always_comb begin
      xs  = zx ? 16'h0000 : x;
      xs  = nx ? ~xs : xs;
      ys  = zy ? 16'h0000 : y;
      ys  = ny ? ~ys : ys;
      res = f ? (xs + ys) : (xs & ys);
      res = no ? ~res : res;
   end

   assign out = res;
   assign zr  = (res == 16'h0000);
   assign ng  = res[15];
endmodule

// File: rtl/hack_computer_cpu.sv
// Single-cycle Hack CPU: A/D registers, ALU, jump logic and the program
// counter, driving the data bus as master.
module pc (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] din,
   output logic [15:0] count
);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= 16'h0000;
      end else if (load) begin
         count <= din;
      end else begin
         count <= count + 16'd1;
      end
   end
endmodule

module cpu
   import hack_computer_pkg::*;
(
   input  logic           clock,
   input  logic           reset,
   input  logic [15:0]    I,
   output logic [15:0]    pc,
   hack_computer_if.master bus
);
   logic [15:0] outAR;
   logic [15:0] outDR;
   logic [15:0] outAM;
   logic [15:0] outALU;
   logic        zx, nx, zy, ny, f, no;
   logic        zr, ng;
   logic        isC;
   logic        isWriteAR;
   logic        isWriteDR;
   logic        isWriteM;
   logic        jump;
   logic        unused_bits;

   assign isC = I[I_TYPE];
   assign zx  = I[I_ZX];
   assign nx  = I[I_NX];
   assign zy  = I[I_ZY];
   assign ny  = I[I_NY];
   assign f   = I[I_F];
   assign no  = I[I_NO];

   assign outAM = I[I_A] ? bus.inM : outAR;

   alu alu (
      .x  (outDR),
      .y  (outAM),
      .zx (zx),
      .nx (nx),
      .zy (zy),
      .ny (ny),
      .f  (f),
      .no (no),
      .out(outALU),
      .zr (zr),
      .ng (ng)
   );

   assign isWriteAR = ~isC | I[D_A];
   assign isWriteDR = isC & I[D_D];
   assign isWriteM  = isC & I[D_M];
   assign jump      = isC & ((I[J_LT] & ng) | (I[J_EQ] & zr) | (I[J_GT] & ~zr & ~ng));

   // A and D commit together with PC and memory; A-instructions load A verbatim.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         outAR <= 16'h0000;
         outDR <= 16'h0000;
      end else begin
         if (isWriteAR) begin
            outAR <= isC ? outALU : I;
         end
         if (isWriteDR) begin
            outDR <= outALU;
         end
      end
   end

   pc pc_reg (
      .clock(clock),
      .reset(reset),
      .load (jump),
      .din  (outAR),
      .count(pc)
   );

   // Gating with reset keeps an aborted instruction from touching memory.
   assign bus.writeM   = isWriteM & reset;
   assign bus.outM     = outALU;
   assign bus.addressM = outAR[14:0];

   assign unused_bits = &{1'b0, I[14:13]};
endmodule

// File: rtl/hack_computer_mem.sv
// Instruction ROM and memory-mapped data space (RAM, screen, keyboard).
module rom32k (
   input  logic [14:0] address,
   output logic [15:0] data
);
   logic [15:0] m [0:32767];

   assign data = m[address];
endmodule

module ram16k (
   input  logic        clock,
   input  logic        we,
   input  logic [13:0] address,
   input  logic [15:0] din,
   output logic [15:0] dout
);
   logic [15:0] m [0:16383];

   always_ff @(posedge clock) begin
      if (we) begin
         m[address] <= din;
      end
   end

   assign dout = m[address];
endmodule

module screen (
   input  logic        clock,
   input  logic        we,
   input  logic [12:0] address,
   input  logic [15:0] din,
   output logic [15:0] dout
);
   logic [15:0] m [0:8191];

   always_ff @(posedge clock) begin
      if (we) begin
         m[address] <= din;
      end
   end

   assign dout = m[address];
endmodule

module memory
   import hack_computer_pkg::*;
(
   input  logic           clock,
   hack_computer_if.slave bus
);
   region_t     region;
   logic [15:0] ram_data;
   logic [15:0] screen_data;
   logic        ram_we;
   logic        screen_we;

   assign region    = decode_region(bus.addressM);
   assign ram_we    = bus.writeM && (region == REGION_RAM);
   assign screen_we = bus.writeM && (region == REGION_SCREEN);

   ram16k ram16k (
      .clock  (clock),
      .we     (ram_we),
      .address(bus.addressM[13:0]),
      .din    (bus.outM),
      .dout   (ram_data)
   );

   screen screen (
      .clock  (clock),
      .we     (screen_we),
      .address(bus.addressM[12:0]),
      .din    (bus.outM),
      .dout   (screen_data)
   );

   // The keyboard has no input port, so it reads as zero like unmapped space.
   always_comb begin
      bus.inM = 16'h0000;
      case (region)
         REGION_RAM:    bus.inM = ram_data;
         REGION_SCREEN: bus.inM = screen_data;
         default:       bus.inM = 16'h0000;
      endcase
   end
endmodule

// File: rtl/hack_computer.sv
// Hack computer root: CPU fetching from the ROM and driving the data memory.
module hack_computer (
   input logic clock,
   input logic reset
);
   hack_computer_if bus ();

   logic [15:0] pc;
   logic [15:0] I;
   logic [15:0] inM;
   logic [15:0] outM;
   logic [14:0] addressM;
   logic        writeM;
   logic        unused_probe;

   rom32k rom (
      .address(pc[14:0]),
      .data   (I)
   );

   cpu cpu (
      .clock(clock),
      .reset(reset),
      .I    (I),
      .pc   (pc),
      .bus  (bus.master)
   );

   memory ram (
      .clock(clock),
      .bus  (bus.slave)
   );

   // Flat copies of the bus kept for hierarchical observation only.
   assign inM      = bus.inM;
   assign outM     = bus.outM;
   assign addressM = bus.addressM;
   assign writeM   = bus.writeM;

   assign unused_probe = ^{pc[15], inM, outM, addressM, writeM};
endmodule

// File: tb/tb_hack_computer.sv
// Scoreboard bench for hack_computer: expectations are queued per cycle as
// each program is loaded and popped/compared as execution reaches them.
module tb_hack_computer;

   typedef enum int {OBS_PC, OBS_D, OBS_A, OBS_RAM, OBS_SCR, OBS_ALU, OBS_NG, OBS_ZR, OBS_WRM} obs_t;

   typedef struct {
      int          cyc;
      obs_t        what;
      int          addr;
      logic [15:0] exp;
      string       name;
   } exp_t;

   logic        clock;
   logic        reset;
   int          compared;
   int          mismatched;
   exp_t        sb[$];
   logic [15:0] prog[$];

   hack_computer dut (
      .clock(clock),
      .reset(reset)
   );

   hack_computer_if mon ();
   assign mon.inM      = dut.inM;
   assign mon.outM     = dut.outM;
   assign mon.addressM = dut.addressM;
   assign mon.writeM   = dut.writeM;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
   endtask

   task automatic load_rom();
      for (int i = 0; i < 64; i++) dut.rom.m[i] = 16'h0000;
      for (int i = 0; i < prog.size(); i++) dut.rom.m[i] = prog[i];
   endtask

   function automatic void expect_at(input int cyc, input obs_t what, input int addr,
                                     input logic [15:0] exp, input string name);
      exp_t e;
      e.cyc = cyc; e.what = what; e.addr = addr; e.exp = exp; e.name = name;
      sb.push_back(e);
   endfunction

   function automatic logic [15:0] observe(input obs_t what, input int addr);
      case (what)
         OBS_PC:  return dut.pc;
         OBS_D:   return dut.cpu.outDR;
         OBS_A:   return {1'b0, mon.addressM};
         OBS_RAM: return dut.ram.ram16k.m[addr];
         OBS_SCR: return dut.ram.screen.m[addr];
         OBS_ALU: return dut.cpu.outALU;
         OBS_NG:  return {15'd0, dut.cpu.ng};
         OBS_ZR:  return {15'd0, dut.cpu.zr};
         OBS_WRM: return {15'd0, mon.writeM};
         default: return 16'hxxxx;
      endcase
   endfunction

   task automatic test_load_store();
      exp_t e; logic [15:0] got;
      prog = '{16'h0005, 16'hEC10, 16'h0002, 16'hE308};
      load_rom();
      dut.ram.ram16k.m[2] = 16'h0000;
      do_reset();
      expect_at(1, OBS_A,   0, 16'h0005, "ls_a_after_at5");
      expect_at(4, OBS_D,   0, 16'h0005, "ls_d");
      expect_at(4, OBS_A,   0, 16'h0002, "ls_a");
      expect_at(4, OBS_RAM, 2, 16'h0005, "ls_ram2");
      for (int c = 1; c <= 4; c++) begin
         tick(1);
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
            if (got !== e.exp) begin
               mismatched++;
               $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_reset();
      exp_t e; logic [15:0] got;
      prog = '{16'hEE88, 16'h0007, 16'hEC10, 16'h0009, 16'hEE88, 16'h0005, 16'hEA87};
      load_rom();
      dut.ram.ram16k.m[0]   = 16'h0055;
      dut.ram.ram16k.m[9]   = 16'h0000;
      dut.ram.ram16k.m[100] = 16'h1234;
      expect_at(0, OBS_PC,  0,   16'h0000, "rst_pc_async");
      expect_at(0, OBS_D,   0,   16'h0000, "rst_d_async");
      expect_at(0, OBS_WRM, 0,   16'h0000, "rst_writem_forced");
      expect_at(1, OBS_PC,  0,   16'h0000, "rst_pc_held");
      expect_at(1, OBS_RAM, 0,   16'h0055, "rst_no_write_held");
      expect_at(2, OBS_RAM, 0,   16'hFFFF, "first_fetch_rom0");
      expect_at(2, OBS_PC,  0,   16'h0001, "first_fetch_pc");
      expect_at(5, OBS_D,   0,   16'h0007, "pre_abort_d");
      expect_at(5, OBS_PC,  0,   16'h0004, "pre_abort_pc");
      expect_at(6, OBS_PC,  0,   16'h0000, "abort_pc_async");
      expect_at(6, OBS_A,   0,   16'h0000, "abort_a_async");
      expect_at(6, OBS_D,   0,   16'h0000, "abort_d_async");
      expect_at(7, OBS_RAM, 9,   16'h0000, "abort_no_write");
      expect_at(7, OBS_RAM, 100, 16'h1234, "ram_not_cleared");
      expect_at(8, OBS_PC,  0,   16'h0001, "resume_pc");
      expect_at(8, OBS_RAM, 0,   16'hFFFF, "resume_rom0");
      for (int ph = 0; ph <= 8; ph++) begin
         case (ph)
            0: begin reset = 1'b0; #1; end
            1: tick(2);
            2: begin reset = 1'b1; tick(1); end
            6: begin reset = 1'b0; #1; end
            7: tick(2);
            8: begin dut.ram.ram16k.m[0] = 16'h0055; reset = 1'b1; tick(1); end
            default: tick(1);
         endcase
         while (sb.size() > 0 && sb[0].cyc == ph) begin
            e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
            if (got !== e.exp) begin
               mismatched++;
               $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_alu();
      exp_t e; logic [15:0] got;
      prog = '{16'h0007, 16'hEC10, 16'hE7D0, 16'hEE90, 16'hEA90, 16'h0005, 16'hEEA8};
      load_rom();
      dut.ram.ram16k.m[5] = 16'h0000;
      do_reset();
      expect_at(2, OBS_D,   0, 16'h0007, "alu_d_eq_a");
      expect_at(3, OBS_D,   0, 16'h0008, "alu_d_plus1");
      expect_at(3, OBS_ALU, 0, 16'hFFFF, "alu_minus1_out");
      expect_at(3, OBS_NG,  0, 16'h0001, "alu_minus1_ng");
      expect_at(3, OBS_ZR,  0, 16'h0000, "alu_minus1_zr");
      expect_at(4, OBS_D,   0, 16'hFFFF, "alu_d_minus1");
      expect_at(4, OBS_ZR,  0, 16'h0001, "alu_zero_zr");
      expect_at(4, OBS_NG,  0, 16'h0000, "alu_zero_ng");
      expect_at(5, OBS_D,   0, 16'h0000, "alu_d_zero");
      expect_at(7, OBS_RAM, 5, 16'hFFFF, "am_write_old_a");
      expect_at(7, OBS_A,   0, 16'h7FFF, "am_a_new");
      for (int c = 1; c <= 7; c++) begin
         tick(1);
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
            if (got !== e.exp) begin
               mismatched++;
               $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_jumps();
      exp_t e; logic [15:0] got;
      prog = '{16'h0003, 16'hEC10, 16'h000A, 16'hE301, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'hEA90, 16'h0014, 16'hE301, 16'h001E, 16'hEA87};
      load_rom();
      do_reset();
      expect_at(2, OBS_D,  0, 16'h0003, "jmp_d3");
      expect_at(4, OBS_PC, 0, 16'h000A, "jgt_taken");
      expect_at(5, OBS_PC, 0, 16'h000B, "after_jump_pc");
      expect_at(5, OBS_D,  0, 16'h0000, "jmp_d0");
      expect_at(7, OBS_PC, 0, 16'h000D, "jgt_not_taken");
      expect_at(9, OBS_PC, 0, 16'h001E, "jmp_uncond");
      for (int c = 1; c <= 9; c++) begin
         tick(1);
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
            if (got !== e.exp) begin
               mismatched++;
               $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_screen_kbd();
      exp_t e; logic [15:0] got;
      prog = '{16'h0005, 16'hEC10, 16'h4002, 16'hEE88, 16'h6000, 16'hEFC8,
               16'hFC10, 16'h6001, 16'hEE88};
      load_rom();
      dut.ram.screen.m[2]      = 16'h0000;
      dut.ram.screen.m[0]      = 16'h2222;
      dut.ram.screen.m[1]      = 16'h5555;
      dut.ram.ram16k.m[16'h2000] = 16'h1111;
      dut.ram.ram16k.m[16'h2001] = 16'h4444;
      do_reset();
      expect_at(2, OBS_D,   0,       16'h0005, "kbd_d_preset");
      expect_at(4, OBS_SCR, 2,       16'hFFFF, "screen2_write");
      expect_at(6, OBS_RAM, 16'h2000, 16'h1111, "kbd_write_ram_alias");
      expect_at(6, OBS_SCR, 0,       16'h2222, "kbd_write_screen_alias");
      expect_at(7, OBS_D,   0,       16'h0000, "kbd_read_zero");
      expect_at(9, OBS_RAM, 16'h2001, 16'h4444, "unmapped_ram_alias");
      expect_at(9, OBS_SCR, 1,       16'h5555, "unmapped_screen_alias");
      for (int c = 1; c <= 9; c++) begin
         tick(1);
         while (sb.size() > 0 && sb[0].cyc == c) begin
            e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
            if (got !== e.exp) begin
               mismatched++;
               $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
            end
         end
      end
   endtask

   task automatic test_multiply();
      exp_t e; logic [15:0] got; int cycles; logic halted;
      prog = '{16'h0002, 16'hEA88, 16'h0000, 16'hFC10, 16'h0010, 16'hE306,
               16'h0002, 16'hFC10, 16'h0001, 16'hF090, 16'h0002, 16'hE308,
               16'h0000, 16'hFC88, 16'h0002, 16'hEA87, 16'h0010, 16'hEA87};
      load_rom();
      dut.ram.ram16k.m[0] = 16'd3;
      dut.ram.ram16k.m[1] = 16'd4;
      dut.ram.ram16k.m[2] = 16'hDEAD;
      do_reset();
      expect_at(0, OBS_RAM, 2, 16'd12, "mult_r2");
      cycles = 0;
      while (!(dut.pc == 16'd16 || dut.pc == 16'd17) && cycles < 180) begin
         tick(1);
         cycles++;
      end
      halted = (dut.pc == 16'd16 || dut.pc == 16'd17);
      compared++;
      if (halted !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mult_timeout: pc %h after %0d cycles, want end loop within 180", dut.pc, cycles);
      end
      while (sb.size() > 0 && sb[0].cyc == 0) begin
         e = sb.pop_front(); got = observe(e.what, e.addr); compared++;
         if (got !== e.exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, want %h", e.name, got, e.exp);
         end
      end
      tick(4);
      halted = (dut.pc == 16'd16 || dut.pc == 16'd17);
      compared++;
      if (halted !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL mult_halt: pc %h, want 0010 or 0011", dut.pc);
      end
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      reset      = 1'b1;
      #1;
      test_load_store();
      test_reset();
      test_alu();
      test_jumps();
      test_screen_kbd();
      test_multiply();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
